// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared types and helpers for the wash cycle sequencer
// Holds the state encoding, latched mode codes, phase_led bit positions,
// the secs_left width and small decode helpers used by the sequencer.
package wm_pkg;

    // All phase durations must fit in this width (<= 255 s).
    localparam int SECS_W = 8;

    localparam int LED_FILL  = 0;
    localparam int LED_WASH  = 1;
    localparam int LED_RINSE = 2;
    localparam int LED_SPIN  = 3;
    localparam int LED_DRY   = 4;
    localparam int LED_ERR   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WASH,
        ST_RINSE,
        ST_SPIN,
        ST_DRY,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [2:0] {
        MODE_NONE,
        MODE_NORM,
        MODE_DELI,
        MODE_HEAVY,
        MODE_DRY
    } mode_t;

    // sel is SW[4:1]; dryer beats heavy beats delicate beats normal.
    function automatic mode_t decode_mode(input logic [4:1] sel);
        if (sel[4])      return MODE_DRY;
        else if (sel[3]) return MODE_HEAVY;
        else if (sel[2]) return MODE_DELI;
        else if (sel[1]) return MODE_NORM;
        else             return MODE_NONE;
    endfunction

    function automatic logic [5:0] phase_led_of(input state_t s);
        logic [5:0] led;
        led = '0;
        case (s)
            ST_FILL:  led[LED_FILL]  = 1'b1;
            ST_WASH:  led[LED_WASH]  = 1'b1;
            ST_RINSE: led[LED_RINSE] = 1'b1;
            ST_SPIN:  led[LED_SPIN]  = 1'b1;
            ST_DRY:   led[LED_DRY]   = 1'b1;
            ST_ERR:   led[LED_ERR]   = 1'b1;
            default:  led = '0;
        endcase
        return led;
    endfunction

    // Fixed programme order; every timed phase eventually lands in DONE.
    function automatic state_t phase_after(input state_t s);
        case (s)
            ST_FILL:  return ST_WASH;
            ST_WASH:  return ST_RINSE;
            ST_RINSE: return ST_SPIN;
            default:  return ST_DONE;
        endcase
    endfunction

endpackage

// File: rtl/sec_tick.sv
// rtl/sec_tick.sv - one-second prescaler with clear and hold
// Ports: clk, rst (async active-high), clear (force count to 0, wins over
// hold), hold (freeze count, suppress tick), tick (one-cycle pulse on the
// last count of each TICK_DIV-cycle period).
module sec_tick #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !clear && !hold && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wash_cycle_seq.sv
// rtl/wash_cycle_seq.sv - paid wash/dry programme sequencer
// Ports: CLK100MHZ clock; BTNC async active-high reset; count credit
// (0 none, 1 cold, >=2 hot); SW[0] pause, SW[4:1] mode select, SW[5] unused;
// bin one-cycle done pulse; busy (not IDLE); phase_led one-hot phase;
// secs_left seconds remaining in the current phase.
module wash_cycle_seq
    import wm_pkg::*;
#(
    parameter int TICK_DIV     = 100000000,
    parameter int FILL_S       = 5,
    parameter int WASH_NORM_S  = 20,
    parameter int WASH_DELI_S  = 10,
    parameter int WASH_HEAVY_S = 30,
    parameter int HOT_EXTRA_S  = 10,
    parameter int RINSE_S      = 10,
    parameter int SPIN_S       = 10,
    parameter int DRY_S        = 30
) (
    input  logic              CLK100MHZ,
    input  logic              BTNC,
    input  logic [3:0]        count,
    input  logic [5:0]        SW,
    output logic              bin,
    output logic              busy,
    output logic [5:0]        phase_led,
    output logic [SECS_W-1:0] secs_left
);

    state_t state;
    mode_t  mode;
    logic   hot;
    logic   armed;

    mode_t             start_mode;
    logic              start_hot;
    logic              start_err;
    state_t            enter_state;
    logic [SECS_W-1:0] enter_secs;
    logic              timed;
    logic              tick_clear;
    logic              tick;
    logic              unused_sw;

    assign unused_sw = SW[5];

    function automatic logic [SECS_W-1:0] phase_dur(input state_t s, input mode_t m, input logic h);
        int w;
        w = 0;
        case (s)
            ST_FILL:  w = FILL_S;
            ST_WASH: begin
                case (m)
                    MODE_NORM:  w = WASH_NORM_S;
                    MODE_DELI:  w = WASH_DELI_S;
                    MODE_HEAVY: w = WASH_HEAVY_S;
                    default:    w = 0;
                endcase
                if (h) begin
                    w = w + HOT_EXTRA_S;
                end
            end
            ST_RINSE: w = RINSE_S;
            ST_SPIN:  w = SPIN_S;
            ST_DRY:   w = DRY_S;
            default:  w = 0;
        endcase
        return w[SECS_W-1:0];
    endfunction

    // Zero-length phases are skipped, so walk forward to the first phase
    // that actually has time in it (or DONE).
    function automatic state_t first_live(input state_t s, input mode_t m, input logic h);
        state_t cur;
        cur = s;
        for (int i = 0; i < 4; i++) begin
            if (cur != ST_DONE && phase_dur(cur, m, h) == '0) begin
                cur = phase_after(cur);
            end
        end
        return cur;
    endfunction

    // From IDLE the target comes from the live switches/credit (about to be
    // latched); otherwise from the latched mode.
    always_comb begin
        start_mode = decode_mode(SW[4:1]);
        start_hot  = (count >= 4'd2);
        start_err  = (start_mode == MODE_NONE) || (start_mode == MODE_DRY && count == 4'd1);
        if (state == ST_IDLE) begin
            enter_state = first_live((start_mode == MODE_DRY) ? ST_DRY : ST_FILL, start_mode, start_hot);
            enter_secs  = phase_dur(enter_state, start_mode, start_hot);
        end else begin
            enter_state = first_live(phase_after(state), mode, hot);
            enter_secs  = phase_dur(enter_state, mode, hot);
        end
    end

    assign timed      = (state == ST_FILL) || (state == ST_WASH) || (state == ST_RINSE) ||
                        (state == ST_SPIN) || (state == ST_DRY);
    // Prescaler sits at 0 outside timed phases, so each phase entry starts
    // a fresh second; phase-to-phase hand-over happens on its wrap.
    assign tick_clear = !timed;

    sec_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_sec_tick (
        .clk  (CLK100MHZ),
        .rst  (BTNC),
        .clear(tick_clear),
        .hold (SW[0]),
        .tick (tick)
    );

    always_ff @(posedge CLK100MHZ or posedge BTNC) begin
        if (BTNC) begin
            state     <= ST_IDLE;
            mode      <= MODE_NONE;
            hot       <= 1'b0;
            armed     <= 1'b1;
            bin       <= 1'b0;
            busy      <= 1'b0;
            phase_led <= '0;
            secs_left <= '0;
        end else begin
            bin <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (armed && count != 4'd0) begin
                        mode <= start_mode;
                        hot  <= start_hot;
                        busy <= 1'b1;
                        if (start_err) begin
                            state     <= ST_ERR;
                            phase_led <= phase_led_of(ST_ERR);
                            secs_left <= '0;
                        end else begin
                            state     <= enter_state;
                            phase_led <= phase_led_of(enter_state);
                            secs_left <= enter_secs;
                            bin       <= (enter_state == ST_DONE);
                        end
                    end else if (count == 4'd0) begin
                        armed <= 1'b1;
                    end
                end
                ST_FILL, ST_WASH, ST_RINSE, ST_SPIN, ST_DRY: begin
                    if (tick) begin
                        // The last second hands over instead of showing 0.
                        if (secs_left == 8'd1) begin
                            state     <= enter_state;
                            phase_led <= phase_led_of(enter_state);
                            secs_left <= enter_secs;
                            bin       <= (enter_state == ST_DONE);
                        end else begin
                            secs_left <= secs_left - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    phase_led <= '0;
                    secs_left <= '0;
                    // Credit must visibly drop to 0 before another run.
                    armed     <= 1'b0;
                end
                ST_ERR: begin
                    if (count == 4'd0) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        phase_led <= '0;
                        armed     <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    phase_led <= '0;
                    secs_left <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_cycle_seq.sv
// tb/tb_wash_cycle_seq.sv - scoreboard bench for wash_cycle_seq
module tb_wash_cycle_seq;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count = 4'd0;
    logic [5:0] sw = 6'd0;
    logic       bin;
    logic       busy;
    logic [5:0] phase_led;
    logic [7:0] secs_left;

    wash_cycle_seq #(
        .TICK_DIV(TD)
    ) dut (
        .CLK100MHZ(clk),
        .BTNC     (rst),
        .count    (count),
        .SW       (sw),
        .bin      (bin),
        .busy     (busy),
        .phase_led(phase_led),
        .secs_left(secs_left)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0] led;
        logic [7:0] secs;
        logic       bin;
        logic       busy;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cyc %0d)", nm, act, req, cyc);
    endtask

    // Monitor: every visible phase change or bin pulse is one observed event.
    logic [5:0] prev_led = 6'd0;
    ev_t        mon_e;
    always @(negedge clk) begin
        if (phase_led != prev_led || bin === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL event: got led=%h secs=%0d bin=%0b busy=%0b at cyc %0d, required no event",
                         phase_led, secs_left, bin, busy, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (phase_led === mon_e.led && secs_left === mon_e.secs && bin === mon_e.bin &&
                    busy === mon_e.busy && cyc == mon_e.cyc) begin
                    n_pass++;
                end else begin
                    $display("FAIL event: got led=%h secs=%0d bin=%0b busy=%0b cyc=%0d, required led=%h secs=%0d bin=%0b busy=%0b cyc=%0d",
                             phase_led, secs_left, bin, busy, cyc,
                             mon_e.led, mon_e.secs, mon_e.bin, mon_e.busy, mon_e.cyc);
                end
            end
        end
        prev_led = phase_led;
    end

    // One programme run. Offsets are relative to s, the first cycle of the run.
    // p_off_in/r_off_in of -2 pick a random point inside the programme, -1 none.
    task automatic run(input logic [5:0] sw0, input logic [3:0] cnt, input logic [5:0] sw_late,
                       input int late_off, input int err_hold, input int p_off_in, input int p_len,
                       input int r_off_in);
        ev_t        plan[$];
        int         s, t, total, p_off, r_off, end_t, mode, wash, nph, pchk_t, pchk_secs;
        logic [5:0] pchk_led;
        logic       hot, err;
        int         leds[4];
        int         durs[4];

        @(posedge clk); #1;
        count = 4'd0;
        sw    = {sw0[5:1], 1'b0};
        repeat (3) @(posedge clk);
        #1;
        count = cnt;
        s     = cyc + 1;

        mode = sw0[4] ? 4 : sw0[3] ? 3 : sw0[2] ? 2 : sw0[1] ? 1 : 0;
        hot  = (cnt >= 4'd2);
        err  = (mode == 0) || (mode == 4 && cnt == 4'd1);
        p_off = -1; r_off = -1; pchk_t = -1; pchk_secs = 0; pchk_led = 6'd0;

        if (err) begin
            plan.push_back(ev_t'{6'h20, 8'd0, 1'b0, 1'b1, s});
            plan.push_back(ev_t'{6'h00, 8'd0, 1'b0, 1'b0, s + err_hold + 1});
            end_t = s + err_hold + 4;
        end else begin
            if (mode == 4) begin
                nph = 1; leds[0] = 'h10; durs[0] = 30;
            end else begin
                wash = ((mode == 1) ? 20 : (mode == 2) ? 10 : 30) + (hot ? 10 : 0);
                nph  = 4;
                leds = '{'h01, 'h02, 'h04, 'h08};
                durs = '{5, wash, 10, 10};
            end
            t = s;
            for (int i = 0; i < nph; i++) begin
                if (durs[i] > 0) plan.push_back(ev_t'{6'(leds[i]), 8'(durs[i]), 1'b0, 1'b1, t});
                t = t + durs[i] * TD;
            end
            total = t - s;
            plan.push_back(ev_t'{6'h00, 8'd0, 1'b1, 1'b1, t});
            r_off = (r_off_in == -2) ? int'($urandom_range(1, total - 1)) : r_off_in;
            if (r_off < 0 && p_len > 0)
                p_off = (p_off_in == -2) ? int'($urandom_range(0, total - 1)) : p_off_in;
            if (p_off >= 0) begin
                foreach (plan[i]) begin
                    if (!plan[i].bin && plan[i].cyc <= s + p_off) begin
                        pchk_led  = plan[i].led;
                        pchk_secs = int'(plan[i].secs) - (s + p_off - plan[i].cyc) / TD;
                    end
                end
                pchk_t = s + p_off + p_len / 2;
                foreach (plan[i]) begin
                    if (plan[i].cyc > s + p_off) plan[i].cyc = plan[i].cyc + p_len;
                end
            end
            if (r_off >= 0) begin
                while (plan.size() > 0 && plan[$].cyc >= s + r_off) void'(plan.pop_back());
                plan.push_back(ev_t'{6'h00, 8'd0, 1'b0, 1'b0, s + r_off});
                end_t = s + r_off + 4;
            end else begin
                end_t = plan[$].cyc + 6;
            end
        end
        foreach (plan[i]) exp_q.push_back(plan[i]);

        while (cyc < end_t) begin
            @(posedge clk); #1;
            if (late_off >= 0 && cyc == s + late_off) sw = {sw_late[5:1], sw[0]};
            if (p_off >= 0 && cyc == s + p_off) sw[0] = 1'b1;
            if (p_off >= 0 && cyc == s + p_off + p_len) sw[0] = 1'b0;
            if (cyc == pchk_t) begin
                chk("pause_secs_hold", int'(secs_left), pchk_secs);
                chk("pause_led_hold", int'(phase_led), int'(pchk_led));
            end
            if (err && cyc == s + err_hold) count = 4'd0;
            if (r_off >= 0 && cyc == s + r_off) begin
                rst   = 1'b1;
                count = 4'd0;
                #1;
                chk("async_reset_busy", int'(busy), 0);
                chk("async_reset_led", int'(phase_led), 0);
                chk("async_reset_secs", int'(secs_left), 0);
            end
            if (r_off >= 0 && cyc == s + r_off + 1) rst = 1'b0;
        end
        // Credit is still present here; the sequencer must stay idle.
        if (!err && r_off < 0) chk("no_restart_stale_credit", int'(busy), 0);
    endtask

    initial begin
        logic [5:0] rs;
        logic [3:0] rc;
        int         pl;
        int         ro;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bin", int'(bin), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_led", int'(phase_led), 0);
        chk("reset_secs", int'(secs_left), 0);
        rst = 1'b0;

        run(6'b000010, 4'd1, 6'd0, -1, 0, -1, 0, -1);        // cold normal
        run(6'b000010, 4'd1, 6'd0, -1, 0, -1, 0, -1);        // restart after 0 then 1
        run(6'b001000, 4'd2, 6'd0, -1, 0, -1, 0, -1);        // hot heavy
        run(6'b010000, 4'd2, 6'd0, -1, 0, -1, 0, -1);        // dryer
        run(6'b010000, 4'd1, 6'd0, -1, 10, -1, 0, -1);       // dryer cold -> ERR
        run(6'b000000, 4'd3, 6'd0, -1, 8, -1, 0, -1);        // no mode -> ERR
        run(6'b000010, 4'd1, 6'd0, -1, 0, 40, 50, -1);       // pause at WASH secs 15
        run(6'b000010, 4'd1, 6'd0, -1, 0, -1, 0, 110);       // reset mid-RINSE
        run(6'b000010, 4'd1, 6'b001000, 5, 0, -1, 0, -1);    // mode change in FILL
        run(6'b011110, 4'd15, 6'd0, -1, 0, -1, 0, -1);       // dryer has priority
        run(6'b000100, 4'd1, 6'd0, -1, 0, -1, 0, -1);        // cold delicate

        for (int n = 0; n < 20; n++) begin
            rs = 6'($urandom) & 6'b111110;
            rc = ($urandom_range(0, 1) == 1) ? 4'd1 : 4'($urandom_range(1, 15));
            pl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 60)) : 0;
            ro = ($urandom_range(0, 4) == 0) ? -2 : -1;
            run(rs, rc, 6'($urandom), int'($urandom_range(1, 30)), int'($urandom_range(1, 20)), -2, pl, ro);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("expect_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wash_cycle_seq.md
Name: wash_cycle_seq

Overview:
- Cycle sequencer that runs the paid wash or dry programme.
- Sits directly upstream of the payment/credit counter: it consumes that stage's credit value (count) and the mode switches, then times the FILL/WASH/RINSE/SPIN or DRY phases.
- On completion it emits the one-cycle "bin" done pulse, which the credit counter edge-detects to clear credit and light its completion LEDs.

Parameters:
- TICK_DIV, 100000000, CLK100MHZ cycles per 1-second tick; benches override this to 4.
- FILL_S, 5, fill phase length in seconds.
- WASH_NORM_S, 20, wash length for SW[1] normal mode.
- WASH_DELI_S, 10, wash length for SW[2] delicate mode.
- WASH_HEAVY_S, 30, wash length for SW[3] heavy mode.
- HOT_EXTRA_S, 10, seconds added to WASH when credit >= 2 (hot).
- RINSE_S, 10, rinse length.
- SPIN_S, 10, spin length.
- DRY_S, 30, dryer run length (SW[4]).

Ports:
- CLK100MHZ  in  1  system clock.
- BTNC  in  1  reset; one clock, reset asynchronous and active-high.
- count  in  4  credit from the payment stage: 0 none, 1 cold, >=2 hot.
- SW  in  6  SW[0] pause, SW[1] normal, SW[2] delicate, SW[3] heavy, SW[4] dryer, SW[5] unused.
- bin  out  1  cycle-done pulse, high exactly one clock.
- busy  out  1  high in any state other than IDLE.
- phase_led  out  6  one-hot: [0] FILL, [1] WASH, [2] RINSE, [3] SPIN, [4] DRY, [5] ERR.
- secs_left  out  8  seconds remaining in the current phase; 0 in IDLE.

Behaviour:
- Reset (async, BTNC=1): state IDLE; bin=0, busy=0, phase_led=0, secs_left=0; prescaler=0; armed=1; latched mode and temperature cleared.
- States: IDLE, FILL, WASH, RINSE, SPIN, DRY, DONE, ERR.
- Mode decode at start, priority SW[4] > SW[3] > SW[2] > SW[1].
  - Mode and hot = (count >= 2) are latched on the start edge.
  - Switch changes after start are ignored, except SW[0].
- IDLE start: condition is armed=1 and count != 0.
  - Dryer with count=1 -> ERR. No mode switch set -> ERR.
  - Dryer mode -> DRY. Any wash mode -> FILL.
  - The state changes on the clock edge after the condition is seen.
- Phase entry: secs_left loads that phase's duration; prescaler clears to 0.
  - WASH duration = mode length + (hot ? HOT_EXTRA_S : 0).
- Ticks: the prescaler counts 0..TICK_DIV-1; a tick occurs on the cycle where it equals TICK_DIV-1, and it then wraps to 0.
  - Each tick decrements secs_left.
  - A tick while secs_left==1 advances to the next phase instead of reaching 0.
  - Each phase therefore lasts exactly duration*TICK_DIV cycles.
- Sequences: FILL->WASH->RINSE->SPIN->DONE for wash modes; DRY->DONE for the dryer.
- Pause: while SW[0]=1 in a timed phase, the prescaler and secs_left hold, and phase_led stays unchanged. On release, timing resumes exactly where it stopped.
- DONE: lasts one cycle with bin=1, busy=1, secs_left=0. Then IDLE, with armed=0.
- Re-arm: armed returns to 1 only after count==0 is seen in IDLE. This prevents a second run on stale credit.
- ERR: phase_led[5]=1, busy=1, no bin pulse. Exits to IDLE once count==0 (armed=1).
- Duration of 0 seconds: the phase is skipped, i.e. the next phase or DONE is entered directly.
- Reset asserted mid-cycle: immediate return to reset values; no bin pulse is generated.
- Pause in IDLE/DONE/ERR: no effect.

Decomposition:
- Shared package wm_pkg holds:
  - the state encoding constants;
  - mode codes (NORM, DELI, HEAVY, DRY);
  - phase_led bit indices;
  - the 8-bit width of secs_left. All durations must be <= 255; a wash of up to 40 s fits.
- One sub-module, sec_tick: prescaler with clear and hold (pause) inputs that emits a one-cycle tick.

Test Plan:
- Cold normal wash, TICK_DIV=4: SW=6'b000010, count 0->1 -> FILL for 20 cycles, WASH 80, RINSE 40, SPIN 40, then a single bin pulse 181 cycles after start is seen. After this, busy=0 and no restart while count stays 1; restart only after count has gone 0 then 1.
- Hot heavy wash: SW[3]=1, count=2 -> WASH secs_left loads 40 and lasts 160 cycles; phase_led one-hot sequence is 0x01, 0x02, 0x04, 0x08.
- Dryer: SW[4]=1, count=2 -> DRY loads 30, lasting 120 cycles, then bin. With SW[4]=1 and count=1 -> ERR, phase_led=0x20, no bin; count=0 -> IDLE.
- Pause: set SW[0]=1 at WASH secs_left=15 for 50 cycles -> secs_left holds at 15 and the prescaler is frozen. Total cycle length grows by exactly 50.
- Reset mid-RINSE: pulse BTNC -> outputs go 0 asynchronously, state IDLE, no bin. Afterwards count=1 (armed=1) starts a fresh FILL.
- Mode change mid-cycle: toggle SW[1]->SW[3] during FILL -> WASH still loads 20 (latched normal mode).
